traffic_light_ctrl: RTL and testbench
=====================================

# traffic_light_ctrl

Traffic-light sequencing FSM for a two-road crossing with a pedestrian crossing. Sits directly downstream of `timer`: it consumes `timer`'s single-cycle `TICK` pulse as its time base and counts ticks to time each light phase. It latches pedestrian requests and supports a night-time flashing-yellow mode. All lamp outputs are registered and drive the lamp drivers directly.

## Interface
- `T_GREEN`, 10: ticks per green phase, main and side roads.
- `T_YELLOW`, 3: ticks per yellow phase.
- `T_ALLRED`, 1: ticks per all-red clearance phase.
- `T_WALK`, 5: ticks per pedestrian walk phase.
- `CNT_W`, 8: phase counter width. Every `T_*` must be in 1..2^CNT_W-1.
- `CLK`  in  1  system clock.
- `RES`  in  1  asynchronous, active-low reset.
- `TICK`  in  1  one-cycle pulse from `timer`. Every cycle it is high counts as one tick.
- `PED_REQ`  in  1  pedestrian button, level or pulse, sampled every cycle.
- `FLASH`  in  1  night mode request, sampled only on tick cycles.
- `MAIN_LIGHT`  out  3  main road lamps {R,Y,G}, one-hot or 000.
- `SIDE_LIGHT`  out  3  side road lamps {R,Y,G}.
- `WALK`  out  1  pedestrian walk lamp.
- `PED_WAIT`  out  1  "request pending" lamp; mirrors the pending latch.

## Operation
- **States:**
  - `AR0` (reset all-red)
  - `MG`, `MY`
  - `AR1`
  - `SG`, `SY`
  - `AR2`
  - `PW` (walk)
  - `FL` (flash)
- **Phase durations:** `MG` and `SG` use `T_GREEN`. `MY` and `SY` use `T_YELLOW`. `AR0`, `AR1` and `AR2` use `T_ALLRED`. `PW` uses `T_WALK`.
- **Phase counter:** `cnt` is cleared on every state entry. On a tick cycle:
  - if `cnt == DUR-1`, the FSM advances;
  - otherwise `cnt` increments.
  - So each phase lasts exactly DUR ticks.
- **Sequence:** `AR0`→`MG`→`MY`→`AR1`→`SG`→`SY`→`AR2`. From `AR2`, go to `PW` if a request is pending, else `MG`. `PW` always goes to `MG`.
- **Lamps per state:**
  - `MG`: main=G, side=R.
  - `MY`: main=Y, side=R.
  - `SG`: main=R, side=G.
  - `SY`: main=R, side=Y.
  - `AR*`: both R.
  - `PW`: both R, `WALK`=1.
  - `WALK`=0 in every state except `PW`.
- **Pedestrian latch `ped_pend`:**
  - Set by `PED_REQ`=1 in any cycle, except while in `PW`, where `PED_REQ` is ignored.
  - Cleared on the `AR2`→`PW` transition edge. If the clear and `PED_REQ`=1 coincide, the clear wins.
  - `PED_WAIT` = `ped_pend`.
- **Flash mode:**
  - Entry: a tick cycle with `FLASH`=1 in any non-`FL` state goes to `FL`. This takes priority over normal advance.
  - In `FL`: `cnt` is cleared and a `blink` bit toggles on every tick. Both roads show Y when `blink`=1 and 000 when `blink`=0. `WALK`=0.
  - Entry sets `blink`=1, so both roads show Y immediately.
  - Exit: a tick with `FLASH`=0 goes to `AR2`, with `cnt`=0.
  - `ped_pend` keeps latching during `FL` and is served from `AR2` as normal.
- **Ticks outside tick cycles:** no state or `cnt` change happens without a tick.

## Timing
- **Reset (`RES`=0, asynchronous):**
  - state=`AR0`, `cnt`=0, `ped_pend`=0, `blink`=0.
  - `MAIN_LIGHT`=100, `SIDE_LIGHT`=100, `WALK`=0, `PED_WAIT`=0.
  - Release is synchronous to `CLK`.
- **Reset mid-phase:** outputs go all-red immediately and asynchronously. Any pending request is lost.
- **Output registers:** all outputs are registered, with next values decoded from next-state.
  - The lamp change is visible right after the same `CLK` edge that samples `TICK`=1 at phase end.
  - Latency is 1 cycle from the tick cycle; there is no additional decode cycle.
- **`PED_WAIT` latency:** rises 1 cycle after the first cycle with `PED_REQ`=1.
- **No illegal lamp combinations:** green or yellow on both roads never occurs, except yellow/yellow in `FL`. No cycle may show G on one road while the other is not R. Every transition out of a green road passes through Y and then an all-red phase. The exception is `FL` entry, which jumps directly to Y/Y.
- **Undefined states:** unused state encodings recover to `AR0` on the next edge.

## Test plan
Bench parameters: `T_GREEN`=4, `T_YELLOW`=2, `T_ALLRED`=1, `T_WALK`=3; `TICK` high 1 cycle in every 5.

1. **Reset and release:** `RES`=0 → all outputs at reset values. Release, then 1 tick → `MAIN`=001 (G), `SIDE`=100.
2. **Full cycle, no requests:** hold for 16 ticks. Check main G 4 ticks, Y 2, R; side G 4 ticks, Y 2; all-red 1 tick between roads; return to `MG` at tick 15. `WALK` stays 0 throughout.
3. **Pedestrian request:** pulse `PED_REQ` 1 cycle during `MG` → `PED_WAIT`=1 next cycle. After `AR2`, `PW` lasts 3 ticks with `WALK`=1 and both roads R. `PED_WAIT` clears on `PW` entry. `PED_REQ` held through `PW` leaves `PED_WAIT`=0.
4. **Flash mode:** `FLASH`=1 at the tick in mid-`SG` → both roads Y. Next tick → 000; next → Y again. Drop `FLASH` at a tick → both R (`AR2`) for 1 tick, then `MG`.
5. **Asynchronous reset mid-walk:** assert `RES`=0 mid-cycle, off-edge, during `PW` → outputs become 100/100/`WALK`=0 without waiting for `CLK`. After release, the sequence restarts from `AR0`.
6. **Coincident request and clear:** `PED_REQ`=1 in the same cycle as the `AR2`→`PW` tick → after the walk, `PED_WAIT`=0 and the next `AR2` goes to `MG`.

Source files
------------

// File: rtl/traffic_light_ctrl.sv
// traffic_light_ctrl: two-road traffic light sequencer with pedestrian walk phase and night flash mode.
// Lamp outputs are registered and decoded from the next state, so they change on the same edge as the state.
module traffic_light_ctrl #(
    parameter int T_GREEN  = 10,
    parameter int T_YELLOW = 3,
    parameter int T_ALLRED = 1,
    parameter int T_WALK   = 5,
    parameter int CNT_W    = 8
) (
    input  logic       CLK,
    input  logic       RES,
    input  logic       TICK,
    input  logic       PED_REQ,
    input  logic       FLASH,
    output logic [2:0] MAIN_LIGHT,
    output logic [2:0] SIDE_LIGHT,
    output logic       WALK,
    output logic       PED_WAIT
);
    typedef enum logic [3:0] {AR0, MG, MY, AR1, SG, SY, AR2, PW, FL} state_t;
    localparam logic [2:0] RED = 3'b100, YEL = 3'b010, GRN = 3'b001, OFF = 3'b000;

    state_t state, nxt, succ;
    logic [CNT_W-1:0] cnt, cnt_nxt, dur;
    logic blink, blink_nxt, ped_pend, pend_nxt;
    logic [2:0] main_nxt, side_nxt;

    assign dur = (state == MG || state == SG) ? CNT_W'(T_GREEN) :
                 (state == MY || state == SY) ? CNT_W'(T_YELLOW) :
                 (state == PW)                ? CNT_W'(T_WALK) : CNT_W'(T_ALLRED);

    assign succ = (state == AR0) ? MG :
                  (state == MG)  ? MY :
                  (state == MY)  ? AR1 :
                  (state == AR1) ? SG :
                  (state == SG)  ? SY :
                  (state == SY)  ? AR2 :
                  (state == AR2) ? (ped_pend ? PW : MG) : MG;

    always_comb begin
        nxt       = state;
        cnt_nxt   = cnt;
        blink_nxt = blink;
        if (state > FL) begin
            nxt       = AR0;
            cnt_nxt   = '0;
            blink_nxt = 1'b0;
        end else if (TICK) begin
            if (FLASH && state != FL) begin
                nxt       = FL;
                cnt_nxt   = '0;
                blink_nxt = 1'b1;
            end else if (state == FL) begin
                nxt       = FLASH ? FL : AR2;
                cnt_nxt   = '0;
                blink_nxt = FLASH & ~blink;
            end else if (cnt == dur - 1'b1) begin
                nxt     = succ;
                cnt_nxt = '0;
            end else begin
                cnt_nxt = cnt + 1'b1;
            end
        end
        // serving the request wins over a press in the same cycle
        pend_nxt = (state == AR2 && nxt == PW) ? 1'b0 : (ped_pend | (PED_REQ && state != PW));
        main_nxt = (nxt == MG) ? GRN : (nxt == MY) ? YEL : (nxt == FL) ? (blink_nxt ? YEL : OFF) : RED;
        side_nxt = (nxt == SG) ? GRN : (nxt == SY) ? YEL : (nxt == FL) ? (blink_nxt ? YEL : OFF) : RED;
    end

    always_ff @(posedge CLK or negedge RES) begin
        if (!RES) begin
            state      <= AR0;
            cnt        <= '0;
            blink      <= 1'b0;
            ped_pend   <= 1'b0;
            MAIN_LIGHT <= RED;
            SIDE_LIGHT <= RED;
            WALK       <= 1'b0;
        end else begin
            state      <= nxt;
            cnt        <= cnt_nxt;
            blink      <= blink_nxt;
            ped_pend   <= pend_nxt;
            MAIN_LIGHT <= main_nxt;
            SIDE_LIGHT <= side_nxt;
            WALK       <= (nxt == PW);
        end
    end

    assign PED_WAIT = ped_pend;
endmodule

// File: tb/tb_traffic_light_ctrl.sv
// tb_traffic_light_ctrl: directed and randomized checks of traffic_light_ctrl against a
// phase-table model that counts remaining ticks per phase.
module tb_traffic_light_ctrl;
    localparam int TG = 4, TY = 2, TA = 1, TW = 3;
    localparam logic [2:0] R = 3'b100, Y = 3'b010, G = 3'b001, O = 3'b000;

    logic CLK = 0, RES = 0, TICK = 0, PED_REQ = 0, FLASH = 0;
    logic [2:0] main_l, side_l;
    logic walk, ped_wait;
    int checks = 0, errors = 0;
    bit cmp_en = 0, hold_req = 0, noise = 0, fl_mode = 0;

    traffic_light_ctrl #(.T_GREEN(TG), .T_YELLOW(TY), .T_ALLRED(TA), .T_WALK(TW), .CNT_W(8)) dut (
        .CLK(CLK), .RES(RES), .TICK(TICK), .PED_REQ(PED_REQ), .FLASH(FLASH),
        .MAIN_LIGHT(main_l), .SIDE_LIGHT(side_l), .WALK(walk), .PED_WAIT(ped_wait)
    );

    always #5 CLK = ~CLK;

    // phases in order: AR0 MG MY AR1 SG SY AR2 PW
    string ms = "RGYRRRRR";
    string ss = "RRRRGYRR";
    int dur_tab[8] = '{TA, TG, TY, TA, TG, TY, TA, TW};
    int m_ph = 0, m_left = TA;
    bit m_pend = 0, m_fl = 0, m_blink = 0, req_ok;

    function automatic logic [2:0] lamp(byte c);
        return (c == "G") ? G : (c == "Y") ? Y : (c == "R") ? R : O;
    endfunction

    function automatic logic [2:0] exp_lamp(string t);
        return m_fl ? (m_blink ? Y : O) : lamp(t[m_ph]);
    endfunction

    always @(posedge CLK or negedge RES) begin
        if (!RES) begin
            m_ph = 0; m_left = TA; m_pend = 0; m_fl = 0; m_blink = 0;
        end else begin
            req_ok = PED_REQ && !(!m_fl && m_ph == 7);
            if (TICK && FLASH && !m_fl) begin
                m_fl = 1; m_blink = 1;
            end else if (TICK && m_fl) begin
                if (FLASH) m_blink = !m_blink;
                else begin m_fl = 0; m_ph = 6; m_left = dur_tab[6]; end
            end else if (TICK) begin
                m_left--;
                if (m_left == 0) begin
                    if (m_ph == 6 && m_pend) begin m_ph = 7; m_pend = 0; req_ok = 0; end
                    else m_ph = (m_ph >= 6) ? 1 : m_ph + 1;
                    m_left = dur_tab[m_ph];
                end
            end
            if (req_ok) m_pend = 1;
        end
    end

    task automatic chk(input string nm, input logic [2:0] act, input logic [2:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %b want %b at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge CLK) if (cmp_en) begin
        chk("cmp_main", main_l, exp_lamp(ms));
        chk("cmp_side", side_l, exp_lamp(ss));
        chk("cmp_walk", {2'b0, walk}, {2'b0, (!m_fl && m_ph == 7)});
        chk("cmp_wait", {2'b0, ped_wait}, {2'b0, m_pend});
    end

    task automatic lit(input string tg, input logic [2:0] m, input logic [2:0] s, input logic w, input logic p);
        chk({tg, "_main"}, main_l, m);
        chk({tg, "_side"}, side_l, s);
        chk({tg, "_walk"}, {2'b0, walk}, {2'b0, w});
        chk({tg, "_wait"}, {2'b0, ped_wait}, {2'b0, p});
    endtask

    // four idle cycles then one tick cycle; returns just after the edge that sampled the tick
    task automatic tk(input bit fl, input bit rq);
        repeat (4) begin
            @(negedge CLK);
            TICK = 0; FLASH = 1'($urandom); PED_REQ = hold_req | (noise && $urandom_range(0, 9) == 0);
        end
        @(negedge CLK);
        TICK = 1; FLASH = fl; PED_REQ = rq | hold_req;
        @(posedge CLK);
        #1;
        TICK = 0; FLASH = 0; PED_REQ = hold_req;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        string em, es;
        em = "GGGGYYRRRRRRRRGG";
        es = "RRRRRRRGGGGYYRRR";
        repeat (3) @(negedge CLK);
        lit("reset", R, R, 0, 0);
        cmp_en = 1;
        RES = 1;
        tk(0, 0);
        lit("t1", G, R, 0, 0);
        for (int k = 1; k < 16; k++) begin
            tk(0, 0);
            lit("cycle", lamp(em[k]), lamp(es[k]), 0, 0);
        end
        @(negedge CLK); PED_REQ = 1;
        @(negedge CLK); PED_REQ = 0;
        chk("wait_rise", {2'b0, ped_wait}, 3'b001);
        repeat (12) tk(0, 0);
        lit("ar2_pend", R, R, 0, 1);
        tk(0, 0);
        lit("pw_entry", R, R, 1, 0);
        hold_req = 1;
        repeat (2) begin
            tk(0, 1);
            lit("pw_hold", R, R, 1, 0);
        end
        hold_req = 0;
        tk(0, 1);
        lit("pw_exit", G, R, 0, 0);
        repeat (7) tk(0, 0);
        lit("sg_mid", R, G, 0, 0);
        tk(1, 0); lit("fl_on", Y, Y, 0, 0);
        tk(1, 0); lit("fl_off", O, O, 0, 0);
        tk(1, 0); lit("fl_on2", Y, Y, 0, 0);
        tk(0, 0); lit("fl_exit", R, R, 0, 0);
        tk(0, 0); lit("fl_mg", G, R, 0, 0);
        tk(0, 1); lit("req2", G, R, 0, 1);
        repeat (12) tk(0, 0);
        lit("ar2_b", R, R, 0, 1);
        tk(0, 1); lit("coinc", R, R, 1, 0);
        repeat (2) tk(0, 0);
        tk(0, 0); lit("coinc_mg", G, R, 0, 0);
        repeat (13) tk(0, 0);
        lit("ar2_c", R, R, 0, 0);
        tk(0, 0); lit("no_walk", G, R, 0, 0);
        tk(0, 1); lit("req3", G, R, 0, 1);
        repeat (12) tk(0, 0);
        lit("ar2_d", R, R, 0, 1);
        tk(0, 0); lit("pw_d", R, R, 1, 0);
        #2 RES = 0;
        #1 lit("async_rst", R, R, 0, 0);
        @(negedge CLK); RES = 1;
        tk(0, 0); lit("restart", G, R, 0, 0);
        noise = 1;
        repeat (300) begin
            if ($urandom_range(0, 11) == 0) fl_mode = !fl_mode;
            tk(fl_mode, $urandom_range(0, 7) == 0);
        end
        noise = 0;
        cmp_en = 0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
